// File: rtl/fifo_access_ctrl_if.sv
// Bundle of producer, FIFO and consumer signals around fifo_access_ctrl.
// The slave modport is the controller's view. The master modport is the view
// of the surrounding producers, FIFO and consumer.
interface fifo_access_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] din0;
    logic [WIDTH-1:0] din1;
    logic             gnt0;
    logic             gnt1;
    logic             fifo_wr_en;
    logic [WIDTH-1:0] fifo_data_in;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_data_out;
    logic             fifo_full;
    logic             fifo_empty;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [LW-1:0]    level;

    modport slave (
        input  req0, req1, din0, din1, fifo_data_out, fifo_full, fifo_empty, out_ready,
        output gnt0, gnt1, fifo_wr_en, fifo_data_in, fifo_rd_en, out_valid, out_data, level
    );

    modport master (
        output req0, req1, din0, din1, fifo_data_out, fifo_full, fifo_empty, out_ready,
        input  gnt0, gnt1, fifo_wr_en, fifo_data_in, fifo_rd_en, out_valid, out_data, level
    );
endinterface

// File: rtl/fifo_access_ctrl.sv
// Two-producer write arbiter and single-consumer read sequencer for an
// external FIFO with one-cycle read latency. Writes are credit-limited by a
// local occupancy count. Reads are issued one at a time.
//
// state | meaning
// IDLE  | no word held; waiting for the FIFO to report data
// ISSUE | fifo_rd_en high for this single cycle
// CAPT  | FIFO read data arrives; latched into out_data at the end of the cycle
// VALID | out_data offered to the consumer until out_ready
module fifo_access_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    fifo_access_ctrl_if.slave bus
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] ONE     = LW'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, VALID} state_t;

    state_t           state_q;
    state_t           state_d;
    logic             rr_q;
    logic             credit;
    logic             gnt0;
    logic             gnt1;
    logic             accept;
    logic             wr_en_q;
    logic [WIDTH-1:0] data_in_q;
    logic             rd_en_q;
    logic [WIDTH-1:0] out_data_q;
    logic [LW-1:0]    level_q;

    // Credit check and round-robin grant decode; rr_q = 1 means port 1 has priority.
    always_comb begin
        credit = !rst && !bus.fifo_full && (level_q < DEPTH_L);
        gnt0   = credit && bus.req0 && (!bus.req1 || !rr_q);
        gnt1   = credit && bus.req1 && (!bus.req0 || rr_q);
        accept = gnt0 || gnt1;
    end

    // Register the accepted word toward the FIFO and advance the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            data_in_q <= '0;
            rr_q      <= 1'b0;
        end else begin
            wr_en_q <= accept;
            if (accept) begin
                data_in_q <= gnt1 ? bus.din1 : bus.din0;
            end
            if (gnt0) begin
                rr_q <= 1'b1;
            end else if (gnt1) begin
                rr_q <= 1'b0;
            end
        end
    end

    // Occupancy: accepted words minus issued reads, saturating at both ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            case ({accept, rd_en_q})
                2'b10: level_q <= level_q + ONE;
                2'b01: if (level_q != '0) level_q <= level_q - ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // Read sequencer next-state logic; fifo_empty is only examined in IDLE and VALID.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!bus.fifo_empty) state_d = ISSUE;
            ISSUE:   state_d = CAPT;
            CAPT:    state_d = VALID;
            VALID:   if (bus.out_ready) state_d = bus.fifo_empty ? IDLE : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    // Read sequencer state, registered read strobe and output data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_en_q    <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q <= state_d;
            rd_en_q <= (state_d == ISSUE);
            if (state_q == CAPT) begin
                out_data_q <= bus.fifo_data_out;
            end
        end
    end

    assign bus.gnt0         = gnt0;
    assign bus.gnt1         = gnt1;
    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_data_in = data_in_q;
    assign bus.fifo_rd_en   = rd_en_q;
    assign bus.out_valid    = (state_q == VALID);
    assign bus.out_data     = out_data_q;
    assign bus.level        = level_q;
endmodule

// File: doc/fifo_access_ctrl.md
FIFO_ACCESS_CTRL -- requirements
Module: fifo_access_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data word width.
REQ-002 SHALL have parameter: DEPTH, 16, word capacity of the attached FIFO (power of two).
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: req0/req1  input  1 each  producer write request.
REQ-006 SHALL have ports: din0/din1  input  WIDTH each  producer write data.
REQ-007 SHALL have ports: gnt0/gnt1  output  1 each  combinational accept pulse; dinX consumed at this edge.
REQ-008 SHALL have ports: fifo_wr_en  output  1, fifo_data_in  output  WIDTH  FIFO write port, registered.
REQ-009 SHALL have ports: fifo_rd_en  output  1  FIFO read strobe, registered; fifo_data_out  input  WIDTH  FIFO read data.
REQ-010 SHALL have ports: fifo_full, fifo_empty  input  1 each  FIFO status flags.
REQ-011 SHALL have ports: out_valid  output  1, out_data  output  WIDTH, out_ready  input  1  consumer valid/ready interface.
REQ-012 SHALL have port: level  output  $clog2(DEPTH)+1  words accepted minus words read.

Function
REQ-013 Write credit: accept allowed only when level < DEPTH and fifo_full = 0.
REQ-014 Arbitration: round-robin between req0/req1; when both asserted, grant the port not granted last; single requester granted whenever credit allows.
REQ-015 At most one of gnt0/gnt1 high per cycle; gnt never asserted without credit.
REQ-016 Write latency: on accept at edge N, fifo_wr_en = 1 and fifo_data_in = granted din in cycle N+1; fifo_wr_en = 0 in cycles with no accept.
REQ-017 Back-to-back accepts on consecutive cycles permitted; one FIFO write per cycle max.
REQ-018 level: +1 on accept, -1 on fifo_rd_en, unchanged on both or neither; range 0..DEPTH, never wraps.
REQ-019 Read FSM states: IDLE, ISSUE, CAPT, VALID.
REQ-020 IDLE -> ISSUE when fifo_empty = 0; else stay.
REQ-021 ISSUE: fifo_rd_en = 1 for exactly this one cycle; -> CAPT unconditionally.
REQ-022 CAPT: out_data <= fifo_data_out at end of cycle (FIFO read latency one cycle); -> VALID.
REQ-023 VALID: out_valid = 1, out_data stable until out_ready = 1; on handshake -> ISSUE if fifo_empty = 0, else IDLE.
REQ-024 fifo_rd_en asserted only in ISSUE; never more than one read outstanding.
REQ-025 Simultaneous accept and read in same cycle both proceed independently.
REQ-026 fifo_empty sampled only in IDLE and VALID; lag of flag after write tolerated by CAPT gap.

Reset
REQ-027 rst = 1 asynchronously: FSM = IDLE, level = 0, fifo_wr_en = 0, fifo_rd_en = 0, out_valid = 0, out_data = 0, fifo_data_in = 0, round-robin pointer favours port 0.
REQ-028 gnt0/gnt1 forced 0 while rst = 1.
REQ-029 Reset mid-operation: pending write and held out_data discarded; FIFO shares rst, so no resync needed.
REQ-030 First accept allowed on first rising edge after rst deasserts.

Verification
REQ-031 Single write: req0 = 1, din0 = 0xAA one cycle -> gnt0 same cycle, fifo_wr_en = 1 with 0xAA next cycle, level = 1.
REQ-032 Contention: req0 = req1 = 1 for 4 cycles, din0 = 0x11, din1 = 0x22 -> grants 0,1,0,1; FIFO receives 0x11,0x22,0x11,0x22.
REQ-033 Full: 16 accepts with no reads -> level = 16, gnt0/gnt1 held 0 while req held; one read -> level = 15, next request granted.
REQ-034 Drain: write 0xF0,0x09,0xAA, out_ready = 1 -> out_data sequence 0xF0,0x09,0xAA, each with fifo_rd_en single-cycle pulse, level ends 0, FSM IDLE.
REQ-035 Backpressure: out_ready = 0 for 5 cycles in VALID -> out_valid = 1, out_data constant, no fifo_rd_en.
REQ-036 Reset mid-stream: rst = 1 during VALID with level = 3 -> out_valid, level, fifo_wr_en, fifo_rd_en all 0 immediately, FSM IDLE.
